sprite_draw_arbiter: RTL and testbench

- Shares the single VGA-adapter plot port (x, y, colour, plot) among several sprite requesters, such as the spaceship, bullet and enemy erase/draw engines.
- Grants one requester at a time, round-robin.
- For the granted requester, it latches the base position and colour, then sweeps a fixed SPR_W x SPR_H pixel box onto the plot port. Pixels outside the screen are clipped.
- Sits between the per-object position controllers and the VGA adapter.

---
 rtl/sprite_draw_arbiter_pkg.sv | 32 +++
 rtl/sprite_draw_arbiter_rr_pick.sv | 36 +++
 rtl/sprite_draw_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_sprite_draw_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_draw_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// draw_pkg
// Shared definitions for the sprite draw arbiter slice:
//   - draw_state_e : arbiter FSM states (IDLE, LOAD, DRAW, DONE)
//   - XW/YW/CW     : default plot-port coordinate and colour widths
//   - SCREEN_W/H   : visible screen area; pixels at or beyond are clipped
//   - BLACK        : colour used by erase engines
//   - idx_w()      : index width for a count, never less than one bit
// -----------------------------------------------------------------------------
package draw_pkg;

  localparam int XW       = 8;
  localparam int YW       = 7;
  localparam int CW       = 3;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] BLACK = 3'b000;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    DRAW = 2'b10,
    DONE = 2'b11
  } draw_state_e;

  // Width needed to index n items; a single item still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_draw_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Searches i_ptr, i_ptr+1, ... modulo
// NREQ and returns the first requester whose request bit is set.
// Ports:
//   i_req   [NREQ-1:0] request vector
//   i_ptr   [PW-1:0]   search start index (0..NREQ-1)
//   o_win   [PW-1:0]   winning requester index (0 when nothing requests)
//   o_valid            high when at least one request is set
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int NREQ = 3,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [PW-1:0]   o_win,
  output logic            o_valid
);

  int w_idx;

  // Walk offsets from farthest to nearest so the closest hit to i_ptr wins.
  always_comb begin
    o_win   = {PW{1'b0}};
    o_valid = 1'b0;
    w_idx   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx   = int'(i_ptr) + k;
      w_idx   = (w_idx >= NREQ) ? (w_idx - NREQ) : w_idx;
      o_win   = i_req[w_idx[PW-1:0]] ? w_idx[PW-1:0] : o_win;
      o_valid = o_valid | i_req[w_idx[PW-1:0]];
    end
  end

endmodule

// File: rtl/sprite_draw_arbiter.sv
// -----------------------------------------------------------------------------
// sprite_draw_arbiter
// Shares one VGA plot port among NREQ sprite engines. A round-robin winner is
// granted, its base position/colour latched, and a SPR_W x SPR_H box swept
// row-major onto the plot port; off-screen pixels are presented with the
// strobe low. All outputs are registered.
// Ports:
//   clk, resetn          clock; asynchronous active-high reset
//   i_req[NREQ]          level draw requests
//   i_req_x/y/colour     flattened per-requester base x, y, colour
//   o_gnt[NREQ]          one-hot grant, LOAD through DONE
//   o_done[NREQ]         one-cycle completion pulse to the winner
//   o_busy               high whenever the FSM is not idle
//   o_vga_x/y/colour     plot coordinates and colour
//   o_vga_plot           plot write strobe
// -----------------------------------------------------------------------------
module sprite_draw_arbiter #(
  parameter int NREQ     = 3,
  parameter int XW       = draw_pkg::XW,
  parameter int YW       = draw_pkg::YW,
  parameter int CW       = draw_pkg::CW,
  parameter int SPR_W    = 4,
  parameter int SPR_H    = 4,
  parameter int SCREEN_W = draw_pkg::SCREEN_W,
  parameter int SCREEN_H = draw_pkg::SCREEN_H
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ*XW-1:0] i_req_x,
  input  logic [NREQ*YW-1:0] i_req_y,
  input  logic [NREQ*CW-1:0] i_req_colour,
  output logic [NREQ-1:0]    o_gnt,
  output logic [NREQ-1:0]    o_done,
  output logic               o_busy,
  output logic [XW-1:0]      o_vga_x,
  output logic [YW-1:0]      o_vga_y,
  output logic [CW-1:0]      o_vga_colour,
  output logic               o_vga_plot
);

  import draw_pkg::*;

  localparam int PW  = idx_w(NREQ);
  localparam int CXW = idx_w(SPR_W);
  localparam int CYW = idx_w(SPR_H);
  localparam int XS  = XW + 1;
  localparam int YS  = YW + 1;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_LOAD = LOAD;
  localparam logic [1:0] S_DRAW = DRAW;
  localparam logic [1:0] S_DONE = DONE;

  localparam logic [XS-1:0]  SCR_W_L = XS'(SCREEN_W);
  localparam logic [YS-1:0]  SCR_H_L = YS'(SCREEN_H);
  localparam logic [CXW-1:0] CX_LAST = CXW'(SPR_W - 1);
  localparam logic [CYW-1:0] CY_LAST = CYW'(SPR_H - 1);

  logic [1:0]      r_state;
  logic [PW-1:0]   r_win;
  logic [PW-1:0]   r_ptr;
  logic [CXW-1:0]  r_cx;
  logic [CYW-1:0]  r_cy;
  logic [XW-1:0]   r_base_x;
  logic [YW-1:0]   r_base_y;
  logic [CW-1:0]   r_base_c;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic            r_busy;
  logic [XW-1:0]   r_vga_x;
  logic [YW-1:0]   r_vga_y;
  logic [CW-1:0]   r_vga_c;
  logic            r_plot;

  logic [PW-1:0]   w_win;
  logic            w_valid;
  logic [XW-1:0]   w_sel_x;
  logic [YW-1:0]   w_sel_y;
  logic [CW-1:0]   w_sel_c;
  logic [XW-1:0]   w_src_x;
  logic [YW-1:0]   w_src_y;
  logic [CW-1:0]   w_src_c;
  logic [CXW-1:0]  w_cx_nxt;
  logic [CYW-1:0]  w_cy_nxt;
  logic [XS-1:0]   w_sum_x;
  logic [YS-1:0]   w_sum_y;
  logic            w_plot;
  logic            w_last;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_win   (w_win),
    .o_valid (w_valid)
  );

  // AND-OR mux of the granted requester's fields off the flattened buses.
  always_comb begin
    w_sel_x = {XW{1'b0}};
    w_sel_y = {YW{1'b0}};
    w_sel_c = {CW{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      w_sel_x = w_sel_x | ({XW{r_win == PW'(i)}} & i_req_x[i*XW +: XW]);
      w_sel_y = w_sel_y | ({YW{r_win == PW'(i)}} & i_req_y[i*YW +: YW]);
      w_sel_c = w_sel_c | ({CW{r_win == PW'(i)}} & i_req_colour[i*CW +: CW]);
    end
  end

  // Next pixel to present: the box origin taken straight from the inputs
  // during LOAD (so the first plot lands one cycle later), else a raster step.
  always_comb begin
    w_last = (r_cx == CX_LAST) && (r_cy == CY_LAST);
    if (r_state == S_LOAD) begin
      w_cx_nxt = {CXW{1'b0}};
      w_cy_nxt = {CYW{1'b0}};
      w_src_x  = w_sel_x;
      w_src_y  = w_sel_y;
      w_src_c  = w_sel_c;
    end else begin
      w_cx_nxt = (r_cx == CX_LAST) ? {CXW{1'b0}} : (r_cx + CXW'(1));
      w_cy_nxt = (r_cx == CX_LAST) ? (r_cy + CYW'(1)) : r_cy;
      w_src_x  = r_base_x;
      w_src_y  = r_base_y;
      w_src_c  = r_base_c;
    end
    // One extra bit so a box hanging off the right/bottom edge is seen as
    // off-screen instead of wrapping back onto it.
    w_sum_x = XS'(w_src_x) + XS'(w_cx_nxt);
    w_sum_y = YS'(w_src_y) + YS'(w_cy_nxt);
    w_plot  = (w_sum_x < SCR_W_L) && (w_sum_y < SCR_H_L);
  end

  // Arbiter FSM with registered grant, done, busy and plot-port outputs.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_state  <= S_IDLE;
      r_win    <= {PW{1'b0}};
      r_ptr    <= {PW{1'b0}};
      r_cx     <= {CXW{1'b0}};
      r_cy     <= {CYW{1'b0}};
      r_base_x <= {XW{1'b0}};
      r_base_y <= {YW{1'b0}};
      r_base_c <= {CW{1'b0}};
      r_gnt    <= {NREQ{1'b0}};
      r_done   <= {NREQ{1'b0}};
      r_busy   <= 1'b0;
      r_vga_x  <= {XW{1'b0}};
      r_vga_y  <= {YW{1'b0}};
      r_vga_c  <= {CW{1'b0}};
      r_plot   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= {NREQ{1'b0}};
          r_plot <= 1'b0;
          if (w_valid) begin
            r_state <= S_LOAD;
            r_win   <= w_win;
            r_gnt   <= NREQ'(1) << w_win;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LOAD: begin
          r_base_x <= w_sel_x;
          r_base_y <= w_sel_y;
          r_base_c <= w_sel_c;
          r_cx     <= w_cx_nxt;
          r_cy     <= w_cy_nxt;
          r_vga_x  <= w_sum_x[XW-1:0];
          r_vga_y  <= w_sum_y[YW-1:0];
          r_vga_c  <= w_src_c;
          r_plot   <= w_plot;
          r_state  <= S_DRAW;
        end
        S_DRAW: begin
          if (w_last) begin
            r_state <= S_DONE;
            r_plot  <= 1'b0;
            r_done  <= r_gnt;
          end else begin
            r_cx    <= w_cx_nxt;
            r_cy    <= w_cy_nxt;
            r_vga_x <= w_sum_x[XW-1:0];
            r_vga_y <= w_sum_y[YW-1:0];
            r_vga_c <= w_src_c;
            r_plot  <= w_plot;
          end
        end
        S_DONE: begin
          r_done  <= {NREQ{1'b0}};
          r_gnt   <= {NREQ{1'b0}};
          r_busy  <= 1'b0;
          r_ptr   <= (r_win == PW'(NREQ - 1)) ? {PW{1'b0}} : (r_win + PW'(1));
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= {NREQ{1'b0}};
          r_done  <= {NREQ{1'b0}};
          r_busy  <= 1'b0;
          r_plot  <= 1'b0;
        end
      endcase
    end
  end

  assign o_gnt        = r_gnt;
  assign o_done       = r_done;
  assign o_busy       = r_busy;
  assign o_vga_x      = r_vga_x;
  assign o_vga_y      = r_vga_y;
  assign o_vga_colour = r_vga_c;
  assign o_vga_plot   = r_plot;

endmodule

// File: tb/tb_sprite_draw_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sprite_draw_arbiter
// Self-checking bench: a table of single-requester draws, hand sequences for
// round-robin order, mid-draw reset, input hold behaviour and fairness, then
// random traffic. A timeline model (grant start + elapsed cycles) predicts
// every output each cycle.
// -----------------------------------------------------------------------------
module tb_sprite_draw_arbiter;

  localparam int NREQ  = 3;
  localparam int XW    = 8;
  localparam int YW    = 7;
  localparam int CW    = 3;
  localparam int SPR_W = 4;
  localparam int SPR_H = 4;
  localparam int SCR_W = 160;
  localparam int SCR_H = 120;
  localparam int NPIX  = SPR_W * SPR_H;

  logic clk = 1'b0;
  logic resetn;
  logic [NREQ-1:0] req;
  logic [XW-1:0] tx [NREQ];
  logic [YW-1:0] ty [NREQ];
  logic [CW-1:0] tc [NREQ];
  logic [NREQ*XW-1:0] req_x_bus;
  logic [NREQ*YW-1:0] req_y_bus;
  logic [NREQ*CW-1:0] req_c_bus;
  logic [NREQ-1:0] gnt, done;
  logic busy, plot;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [CW-1:0] vga_c;

  assign req_x_bus = {tx[2], tx[1], tx[0]};
  assign req_y_bus = {ty[2], ty[1], ty[0]};
  assign req_c_bus = {tc[2], tc[1], tc[0]};

  always #5 clk = ~clk;

  sprite_draw_arbiter #(
    .NREQ(NREQ), .XW(XW), .YW(YW), .CW(CW), .SPR_W(SPR_W), .SPR_H(SPR_H),
    .SCREEN_W(SCR_W), .SCREEN_H(SCR_H)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .i_req        (req),
    .i_req_x      (req_x_bus),
    .i_req_y      (req_y_bus),
    .i_req_colour (req_c_bus),
    .o_gnt        (gnt),
    .o_done       (done),
    .o_busy       (busy),
    .o_vga_x      (vga_x),
    .o_vga_y      (vga_y),
    .o_vga_colour (vga_c),
    .o_vga_plot   (plot)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Model: when active, m_t counts cycles since the grant (0 = LOAD,
  // 1..NPIX = pixels, NPIX+1 = done pulse).
  bit m_act;
  int m_t, m_win, m_ptr, m_bx, m_by, m_c;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_act = 1'b0; m_t = 0; m_win = 0; m_ptr = 0;
  endtask

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_edge();
    if (!m_act) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (req[idx]) begin
          m_win = idx; m_act = 1'b1; m_t = 0;
          break;
        end
      end
    end else begin
      if (m_t == 0) begin
        m_bx = int'(tx[m_win]); m_by = int'(ty[m_win]); m_c = int'(tc[m_win]);
      end
      m_t++;
      if (m_t == NPIX + 2) begin
        m_act = 1'b0;
        m_ptr = (m_win + 1) % NREQ;
      end
    end
  endtask

  task automatic compare_all();
    int eg, ed, p, ex, ey;
    eg = m_act ? (1 << m_win) : 0;
    ed = (m_act && m_t == NPIX + 1) ? (1 << m_win) : 0;
    chk("gnt", gnt, eg);
    chk("busy", busy, m_act ? 1 : 0);
    chk("done", done, ed);
    if (m_act && m_t >= 1 && m_t <= NPIX) begin
      p  = m_t - 1;
      ex = m_bx + (p % SPR_W);
      ey = m_by + (p / SPR_W);
      chk("vga_x", vga_x, ex % (1 << XW));
      chk("vga_y", vga_y, ey % (1 << YW));
      chk("vga_colour", vga_c, m_c);
      chk("vga_plot", plot, (ex < SCR_W && ey < SCR_H) ? 1 : 0);
    end else begin
      chk("vga_plot_idle", plot, 0);
    end
  endtask

  task automatic tick();
    if (resetn) model_reset(); else model_edge();
    @(posedge clk); #1;
    cyc++;
    compare_all();
  endtask

  task automatic drain();
    for (int k = 0; k < 3 * NPIX && busy; k++) tick();
    chk("drain_idle", busy, 0);
  endtask

  task automatic apply_reset();
    resetn = 1'b1;
    #1;
    model_reset();
    chk("rst_gnt", gnt, 0);   chk("rst_done", done, 0); chk("rst_busy", busy, 0);
    chk("rst_x", vga_x, 0);   chk("rst_y", vga_y, 0);
    chk("rst_c", vga_c, 0);   chk("rst_plot", plot, 0);
    tick(); tick();
    resetn = 1'b0;
  endtask

  typedef struct {
    int ri; int x; int y; int c;
    logic [NREQ-1:0] exp_gnt;
    int exp_strobes; int exp_done_cyc;
  } vec_t;

  vec_t vt [5];
  logic [NREQ-1:0] order [4];
  logic [NREQ-1:0] prev_gnt;
  int n_ord, strobes, dcyc;
  bit seen_done;

  initial begin
    vt[0] = '{0, 10,  20,  6, 3'b001, 16, 18};
    vt[1] = '{1, 158, 118, 5, 3'b010, 4,  18};
    vt[2] = '{2, 157, 0,   3, 3'b100, 12, 18};
    vt[3] = '{0, 255, 119, 1, 3'b001, 0,  18};
    vt[4] = '{1, 0,   117, 7, 3'b010, 12, 18};

    req = '0;
    for (int i = 0; i < NREQ; i++) begin tx[i] = '0; ty[i] = '0; tc[i] = '0; end
    #2;
    apply_reset();

    // Table-driven single-requester draws.
    for (int v = 0; v < 5; v++) begin
      tx[vt[v].ri] = XW'(vt[v].x); ty[vt[v].ri] = YW'(vt[v].y); tc[vt[v].ri] = CW'(vt[v].c);
      req = NREQ'(1) << vt[v].ri;
      cyc = 0; strobes = 0; dcyc = -1;
      for (int k = 1; k <= 19; k++) begin
        tick();
        if (k == 1) chk("vec_gnt", gnt, vt[v].exp_gnt);
        if (k == 2) begin
          chk("vec_first_x", vga_x, vt[v].x % 256);
          chk("vec_first_y", vga_y, vt[v].y % 128);
        end
        if (plot) strobes++;
        if (done != '0 && dcyc < 0) dcyc = k;
        if (done[vt[v].ri]) req = '0;
        if (k == 19) chk("vec_busy_low", busy, 0);
      end
      chk("vec_strobes", strobes, vt[v].exp_strobes);
      chk("vec_done_cyc", dcyc, vt[v].exp_done_cyc);
    end

    // All three requesting from rr_ptr = 0: grant order 0,1,2,0.
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      tx[i] = XW'($urandom); ty[i] = YW'($urandom); tc[i] = CW'($urandom);
    end
    req = 3'b111; prev_gnt = '0; n_ord = 0;
    for (int k = 0; k < 4 * (NPIX + 4) + 8 && n_ord < 4; k++) begin
      tick();
      if (gnt != '0 && prev_gnt == '0) begin order[n_ord] = gnt; n_ord++; end
      prev_gnt = gnt;
    end
    chk("rr_grants_seen", n_ord, 4);
    chk("rr_order0", order[0], 3'b001);
    chk("rr_order1", order[1], 3'b010);
    chk("rr_order2", order[2], 3'b100);
    chk("rr_order3", order[3], 3'b001);
    req = '0;
    drain();

    // Reset in the middle of a draw by requester 2.
    tx[2] = 8'd30; ty[2] = 7'd40; tc[2] = 3'd5;
    req = 3'b100; cyc = 0;
    for (int k = 1; k <= 7; k++) tick();
    chk("pre_abort_busy", busy, 1);
    apply_reset();
    req = '0;
    seen_done = 1'b0;
    for (int k = 0; k < 4; k++) begin tick(); if (done != '0) seen_done = 1'b1; end
    chk("abort_no_done", seen_done, 0);
    req = 3'b111;
    tick();
    chk("restart_ptr0", gnt, 3'b001);
    req = '0;
    drain();

    // Inputs sampled only in LOAD: x changes at cycle 3, req drops at cycle 5.
    tx[2] = 8'd40; ty[2] = 7'd50; tc[2] = 3'd2;
    req = 3'b100; cyc = 0; dcyc = -1;
    for (int k = 1; k <= 19; k++) begin
      tick();
      if (k == 2) chk("hold_first_x", vga_x, 40);
      if (k == 3) tx[2] = 8'd99;
      if (k == 5) req[2] = 1'b0;
      if (k == 17) begin
        chk("hold_last_x", vga_x, 43);
        chk("hold_last_y", vga_y, 53);
      end
      if (done[2] && dcyc < 0) dcyc = k;
    end
    chk("hold_done_cyc", dcyc, 18);

    // Requester 0 held continuously; requester 1 joins at cycle 5.
    tx[0] = 8'd5; ty[0] = 7'd5; tc[0] = 3'd1;
    tx[1] = 8'd60; ty[1] = 7'd60; tc[1] = 3'd4;
    req = 3'b001; cyc = 0; seen_done = 1'b0; n_ord = 0;
    for (int k = 1; k <= 3 * NPIX && n_ord == 0; k++) begin
      tick();
      if (k == 5) req[1] = 1'b1;
      if (seen_done && gnt != '0) begin
        chk("fair_next_gnt", gnt, 3'b010);
        n_ord = 1;
      end
      if (done[0]) seen_done = 1'b1;
    end
    chk("fair_grant_seen", n_ord, 1);
    req = '0;
    drain();

    // Random traffic; each requester holds its request until it sees done.
    for (int k = 0; k < 2500; k++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (done[i]) begin
          req[i] = $urandom_range(1, 0) == 1;
          tx[i] = XW'($urandom); ty[i] = YW'($urandom); tc[i] = CW'($urandom);
        end else if (!req[i] && $urandom_range(5, 0) == 0) begin
          req[i] = 1'b1;
          tx[i] = XW'($urandom); ty[i] = YW'($urandom); tc[i] = CW'($urandom);
        end
      end
    end
    req = '0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
